// File: rtl/fp_addsub_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_addsub_scheduler_if
// Description : Request, shared-unit and response channels of the FP add/sub
//               scheduler, with scheduler-side (master) and environment-side
//               (slave) modports.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_addsub_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_op;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;

    logic                  unit_start;
    logic                  unit_op;
    logic [31:0]           unit_a;
    logic [31:0]           unit_b;
    logic                  unit_done;
    logic [31:0]           unit_result;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic                  rsp_error;

    modport master (
        input  req_valid, req_op, req_a, req_b, unit_done, unit_result, rsp_ready,
        output req_ready, unit_start, unit_op, unit_a, unit_b,
               rsp_valid, rsp_id, rsp_result, rsp_error
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, unit_done, unit_result, rsp_ready,
        input  req_ready, unit_start, unit_op, unit_a, unit_b,
               rsp_valid, rsp_id, rsp_result, rsp_error
    );
endinterface
`default_nettype wire

// File: rtl/fp_addsub_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fp_addsub_scheduler
// Description : Round-robin sharing of one multi-cycle FP32 add/sub unit with
//               a local fast path; FP_SCHED_TIMEOUT_EN adds a WAIT watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_addsub_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  wire logic              clock,
    input  wire logic              reset,
    fp_addsub_scheduler_if.master  bus,
    output logic                   busy
);
    if ((ID_W < $clog2(NUM_REQ)) || (NUM_REQ < 2) || (TIMEOUT < 1)) begin : g_param_check
        $error("fp_addsub_scheduler: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] w_grant;
    logic [ID_W-1:0] w_next_ptr;
    logic [ID_W:0]   w_scan;
    logic            w_found;
    logic            w_accept;
    logic            w_op;
    logic [31:0]     w_a;
    logic [31:0]     w_b;
    logic            w_fast_zero;
    logic            w_fast_pass;
    logic            w_timeout;
    logic            r_unit_op;
    logic [31:0]     r_unit_a;
    logic [31:0]     r_unit_b;
    logic [ID_W-1:0] r_rsp_id;
    logic [31:0]     r_rsp_result;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_scan  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
            if (w_scan >= (ID_W+1)'(NUM_REQ)) begin
                w_scan = w_scan - (ID_W+1)'(NUM_REQ);
            end
            if (!w_found && bus.req_valid[w_scan[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_scan[ID_W-1:0];
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (r_state == S_IDLE && w_found) begin
            bus.req_ready[w_grant] = 1'b1;
        end
    end

    assign w_accept    = (r_state == S_IDLE) && w_found;
    assign w_op        = bus.req_op[w_grant];
    assign w_a         = bus.req_a[{w_grant, 5'b0} +: 32];
    assign w_b         = bus.req_b[{w_grant, 5'b0} +: 32];
    assign w_fast_zero = w_op && (w_a == w_b);
    assign w_fast_pass = (w_b[30:0] == 31'd0);
    assign w_next_ptr  = (w_grant == ID_W'(NUM_REQ-1)) ? '0 : w_grant + 1'b1;

`ifdef FP_SCHED_TIMEOUT_EN
    localparam int                c_CNT_W   = $clog2(TIMEOUT+1);
    localparam logic [c_CNT_W-1:0] c_WD_LAST = c_CNT_W'(TIMEOUT-1);
    localparam logic [31:0]       c_QNAN    = 32'h7FC0_0000;

    logic [c_CNT_W-1:0] r_wd_cnt;
    logic               r_rsp_error;

    // A completion in the final watchdog cycle takes precedence over the abort.
    assign w_timeout     = (r_state == S_WAIT) && !bus.unit_done && (r_wd_cnt == c_WD_LAST);
    assign bus.rsp_error = r_rsp_error;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wd_cnt    <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_wd_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_accept) begin
                r_rsp_error <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_error <= 1'b1;
            end
        end
    end
`else
    assign w_timeout     = 1'b0;
    assign bus.rsp_error = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_fast_zero || w_fast_pass) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT: begin
                if (bus.unit_done || w_timeout) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Unit operands only change when an operation is actually issued.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_unit_op    <= 1'b0;
            r_unit_a     <= '0;
            r_unit_b     <= '0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
        end else begin
            if (w_accept) begin
                r_rr_ptr <= w_next_ptr;
                r_rsp_id <= w_grant;
                if (w_fast_zero) begin
                    r_rsp_result <= 32'h0000_0000;
                end else if (w_fast_pass) begin
                    r_rsp_result <= w_a;
                end else begin
                    r_unit_op <= w_op;
                    r_unit_a  <= w_a;
                    r_unit_b  <= w_b;
                end
            end
            if (r_state == S_WAIT && bus.unit_done) begin
                r_rsp_result <= bus.unit_result;
            end
`ifdef FP_SCHED_TIMEOUT_EN
            else if (w_timeout) begin
                r_rsp_result <= c_QNAN;
            end
`endif
        end
    end

    assign bus.unit_start = (r_state == S_ISSUE);
    assign bus.unit_op    = r_unit_op;
    assign bus.unit_a     = r_unit_a;
    assign bus.unit_b     = r_unit_b;
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign busy           = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_addsub_scheduler
// Description : Directed vector bench for fp_addsub_scheduler with a simple
//               variable-latency unit model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_scheduler;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic busy;

    fp_addsub_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    fp_addsub_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    // Unit model: done is high on the ulat-th cycle counting the start cycle.
    int          ulat       = 3;
    bit          unit_en    = 1'b1;
    logic [31:0] unit_val   = 32'h0;
    logic        stray_done = 1'b0;
    int          ucnt       = 0;

    always @(posedge clock) begin
        if (reset)                          ucnt <= 0;
        else if (bus.unit_start && unit_en) ucnt <= ulat - 1;
        else if (ucnt > 0)                  ucnt <= ucnt - 1;
    end

    assign bus.unit_done   = (ucnt == 1) | stray_done;
    assign bus.unit_result = unit_val;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          id;
        bit          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          fast;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int id, input bit op, input logic [31:0] a, input logic [31:0] b);
        bus.req_op[id]          = op;
        bus.req_a[32*id +: 32]  = a;
        bus.req_b[32*id +: 32]  = b;
        bus.req_valid[id]       = 1'b1;
    endtask

    task automatic wait_accept(input int id, input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (bus.req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_accept"}, 32'(ok), 32'd1);
        @(posedge clock);
        #1;
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output int starts);
        lat    = 0;
        starts = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            lat++;
            if (bus.unit_start) starts++;
            if (bus.rsp_valid) break;
        end
    endtask

    task automatic run_op(input string name, input int id, input bit op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input int exp_lat,
                          input int exp_starts, input bit exp_err);
        int lat, starts;
        drive_req(id, op, a, b);
        wait_accept(id, name);
        wait_rsp(lat, starts);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_starts"}, 32'(starts), 32'(exp_starts));
        check({name, "_id"}, 32'(bus.rsp_id), 32'(id));
        check({name, "_result"}, bus.rsp_result, res);
        check({name, "_error"}, 32'(bus.rsp_error), 32'(exp_err));
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] fa [4];
        int          lat, starts;
        bit          saw_valid;

        tbl[0] = '{0, 1'b1, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0};
        tbl[1] = '{2, 1'b1, 32'h4120_0000, 32'h4120_0000, 32'h0000_0000, 1'b1};
        tbl[2] = '{1, 1'b0, 32'hC0A0_0000, 32'h8000_0000, 32'hC0A0_0000, 1'b1};
        tbl[3] = '{3, 1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0};
        tbl[4] = '{1, 1'b1, 32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 1'b1};
        tbl[5] = '{0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        tbl[6] = '{2, 1'b0, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0};
        tbl[7] = '{3, 1'b1, 32'h40A0_0000, 32'h4040_0000, 32'h4000_0000, 1'b0};

        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_unit_start", 32'(bus.unit_start), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_unit_a", bus.unit_a, 32'd0);
        check("reset_rsp_result", bus.rsp_result, 32'd0);
        check("reset_req_ready", 32'(bus.req_ready), 32'd0);

        for (int v = 0; v < 8; v++) begin
            unit_val = tbl[v].res;
            run_op($sformatf("vec%0d", v), tbl[v].id, tbl[v].op, tbl[v].a, tbl[v].b, tbl[v].res,
                   tbl[v].fast ? 1 : 4, tbl[v].fast ? 0 : 1, 1'b0);
        end

        // All requesters held valid: last grant was 3, so order is 0,1,2,3,0.
        fa[0] = 32'h4000_0000; fa[1] = 32'h4040_0000; fa[2] = 32'h4080_0000; fa[3] = 32'h40A0_0000;
        for (int r = 0; r < 4; r++) drive_req(r, 1'b0, fa[r], 32'h0);
        for (int g = 0; g < 5; g++) begin
            saw_valid = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clock);
                if (bus.rsp_valid) begin
                    saw_valid = 1'b1;
                    break;
                end
            end
            check($sformatf("rr%0d_id", g), saw_valid ? 32'(bus.rsp_id) : 32'hFFFF_FFFF, 32'(g % 4));
            check($sformatf("rr%0d_result", g), bus.rsp_result, fa[g % 4]);
            @(posedge clock);
        end
        #1 bus.req_valid = '0;

        // Response stall with another requester waiting.
        bus.rsp_ready = 1'b0;
        drive_req(1, 1'b0, 32'h3F80_0000, 32'h8000_0000);
        wait_accept(1, "stall");
        drive_req(3, 1'b1, 32'h4000_0000, 32'h4000_0000);
        wait_rsp(lat, starts);
        check("stall_latency", 32'(lat), 32'd1);
        for (int s = 0; s < 5; s++) begin
            @(negedge clock);
            check($sformatf("stall%0d_valid", s), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("stall%0d_id", s), 32'(bus.rsp_id), 32'd1);
            check($sformatf("stall%0d_result", s), bus.rsp_result, 32'h3F80_0000);
            check($sformatf("stall%0d_ready", s), 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        check("stall_release", 32'(bus.rsp_valid), 32'd0);

        // Reset while waiting on the unit, then a stray completion.
        unit_en = 1'b0;
        drive_req(2, 1'b0, 32'h3F80_0000, 32'h3F80_0000);
        wait_accept(2, "rstwait");
        @(negedge clock);
        @(negedge clock);
        check("rstwait_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        stray_done = 1'b1;
        @(negedge clock);
        stray_done = 1'b0;
        saw_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (bus.rsp_valid) saw_valid = 1'b1;
        end
        check("rstwait_no_rsp", 32'(saw_valid), 32'd0);
        check("rstwait_busy_low", 32'(busy), 32'd0);
        check("rstwait_unit_a", bus.unit_a, 32'd0);
        check("rstwait_unit_b", bus.unit_b, 32'd0);
        check("rstwait_unit_op", 32'(bus.unit_op), 32'd0);
        check("rstwait_rsp_result", bus.rsp_result, 32'd0);
        check("rstwait_rsp_id", 32'(bus.rsp_id), 32'd0);
        // rr_ptr back at 0 means requester 1 wins over 3.
        @(posedge clock);
        #1;
        drive_req(1, 1'b0, 32'h3F80_0000, 32'h0);
        drive_req(3, 1'b0, 32'h4000_0000, 32'h0);
        @(negedge clock);
        check("rstwait_rr_ptr", 32'(bus.req_ready), 32'h2);
        bus.req_valid = '0;
        unit_en = 1'b1;
        @(posedge clock);
        #1;

`ifdef FP_SCHED_TIMEOUT_EN
        unit_en = 1'b0;
        run_op("timeout", 0, 1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000, TIMEOUT + 2, 1, 1'b1);
        unit_en  = 1'b1;
        ulat     = TIMEOUT + 1;
        unit_val = 32'h4000_0000;
        run_op("lastcycle", 1, 1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, TIMEOUT + 2, 1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fp_addsub_scheduler.md
Name: fp_addsub_scheduler

Overview:
Round-robin scheduler that shares one multi-cycle IEEE-754 single-precision add/subtract unit between NUM_REQ requesters. It accepts one operation at a time over a valid/ready handshake and issues it to the shared unit with a start/done handshake. It returns the result with the requester ID over a valid/ready response channel. Trivial subtract cases bypass the unit through a local fast path.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester index; must be at least clog2(NUM_REQ)
TIMEOUT, 64, watchdog limit in cycles (used only with FP_SCHED_TIMEOUT_EN)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
req_op  in  NUM_REQ  per-requester op: 0 = add, 1 = subtract
req_a  in  32*NUM_REQ  operand A; requester i uses bits [32i+31:32i]
req_b  in  32*NUM_REQ  operand B; same packing as req_a
unit_start  out  1  one-cycle start pulse to the shared unit
unit_op  out  1  op to the unit (registered)
unit_a  out  32  operand A to the unit (registered)
unit_b  out  32  operand B to the unit (registered)
unit_done  in  1  unit result valid, one cycle
unit_result  in  32  unit result
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accept
rsp_id  out  ID_W  index of the requester that is served
rsp_result  out  32  result
rsp_error  out  1  watchdog abort flag (always 0 without the macro)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; rr_ptr = 0; all outputs 0. Reset mid-operation abandons the operation with no response.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = first asserted req_valid scanning rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ.
  - req_ready[grant] is driven combinationally, and only in IDLE.
  - On accept (valid & ready): capture op, a, b and the ID, then set rr_ptr = (grant+1) mod NUM_REQ.
- Fast path, evaluated on accept:
  - op = 1 and a == b bitwise: result 0x00000000, go to RESP.
  - b[30:0] == 0 (either op): result a unchanged, go to RESP.
  - Otherwise go to ISSUE.
- ISSUE: unit_start = 1 for exactly one cycle with operands valid; go to WAIT.
- WAIT: unit_done is sampled only in this state. On unit_done, capture unit_result and go to RESP. unit_done in any other state is ignored.
- RESP:
  - rsp_valid = 1; rsp_id and rsp_result are held stable until rsp_ready.
  - When rsp_valid & rsp_ready: go to IDLE. A new accept is possible the following cycle; there is no back-to-back accept in the RESP cycle.
- Latency, with accept at cycle T:
  - Fast path: rsp_valid at T+1.
  - Unit path: unit_start at T+1; rsp_valid the cycle after unit_done.
- Requester rules: it may drop valid before it is accepted. Its data must be stable while valid is high.
- Fairness: a requester with valid held high is served within NUM_REQ grants.
- unit_a, unit_b and unit_op hold their last values when idle.

Optional Feature:
- Macro: FP_SCHED_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to WAIT and increments each cycle in WAIT.
  - If it reaches TIMEOUT without unit_done: go to RESP with rsp_result 0x7FC00000 (qNaN) and rsp_error = 1.
  - unit_done in the same cycle as the timeout wins: normal result, rsp_error = 0.
- Without the macro: no counter; WAIT waits forever; rsp_error is tied to 0.

Test Plan:
- Unit model with 3-cycle latency; req 0: 0x40400000 - 0x3F800000 -> unit_start once, rsp_result 0x40000000, rsp_id 0, rsp_valid 4 cycles after accept.
- Req 2: sub 0x41200000, 0x41200000 -> no unit_start, rsp_result 0x00000000 at T+1. Req 1: add 0xC0A00000, 0x80000000 -> rsp_result 0xC0A00000.
- All 4 requesters held valid continuously -> grants in order 0, 1, 2, 3, 0; rr_ptr wraps correctly.
- rsp_ready held low 5 cycles -> rsp_valid, rsp_id and rsp_result stable; no req_ready during the stall.
- Reset asserted in WAIT, then a stray unit_done -> no rsp_valid, all outputs 0, rr_ptr 0.
- With FP_SCHED_TIMEOUT_EN and TIMEOUT = 8, unit never completes -> rsp_result 0x7FC00000, rsp_error 1 at 8 cycles into WAIT; separately, unit_done on cycle 8 -> normal result, rsp_error 0.
